// File: rtl/uart_tx_scheduler.sv
// Paces characters from a TX FIFO into a UART transmitter: start, acknowledge, completion, gap.
// All outputs registered (start one cycle after a head is seen); waits on tx_busy_i and only pulls when fifo_load_i is high.
module uart_tx_scheduler #(
    parameter int DATA_SIZE   = 8,
    parameter int GAP_WIDTH   = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [GAP_WIDTH-1:0] gap_i,
    input  logic                 fifo_load_i,
    input  logic [DATA_SIZE-1:0] fifo_data_i,
    output logic                 fifo_pull_o,
    input  logic                 tx_busy_i,
    output logic                 tx_start_o,
    output logic [DATA_SIZE-1:0] tx_data_o,
    output logic [CNT_WIDTH-1:0] sent_cnt_o,
    output logic                 drain_o,
    output logic                 err_o
);

    localparam int ACK_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0] ACK_INIT = ACK_W'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ACK_W-1:0]       ack_q, ack_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;
    logic [DATA_SIZE-1:0]   data_d;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   pull_d, start_d, drain_d, err_d;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        gap_d   = gap_q;
        data_d  = tx_data_o;
        cnt_d   = sent_cnt_o;
        pull_d  = 1'b0;
        start_d = 1'b0;
        drain_d = 1'b0;
        err_d   = err_o;

        // Soft clear wins over everything and drops any in-flight character uncounted.
        if (clear_i) begin
            state_d = IDLE;
            ack_d   = '0;
            gap_d   = '0;
            data_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i && fifo_load_i && !tx_busy_i) begin
                        data_d  = fifo_data_i;
                        pull_d  = 1'b1;
                        start_d = 1'b1;
                        ack_d   = ACK_INIT;
                        state_d = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy_i) begin
                        ack_d   = '0;
                        state_d = WAIT_DONE;
                    end else if (ack_q <= ACK_W'(1)) begin
                        ack_d   = '0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ack_d = ack_q - ACK_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        cnt_d = sent_cnt_o + CNT_WIDTH'(1);
                        if (gap_i == '0) begin
                            state_d = IDLE;
                            drain_d = !fifo_load_i;
                        end else begin
                            gap_d   = gap_i;
                            state_d = GAP;
                        end
                    end
                end
                GAP: begin
                    // Leaving at 1 gives exactly gap_i cycles spent here.
                    if (gap_q <= GAP_WIDTH'(1)) begin
                        gap_d   = '0;
                        state_d = IDLE;
                        drain_d = !fifo_load_i;
                    end else begin
                        gap_d = gap_q - GAP_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            ack_q       <= '0;
            gap_q       <= '0;
            tx_data_o   <= '0;
            sent_cnt_o  <= '0;
            fifo_pull_o <= 1'b0;
            tx_start_o  <= 1'b0;
            drain_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            gap_q       <= gap_d;
            tx_data_o   <= data_d;
            sent_cnt_o  <= cnt_d;
            fifo_pull_o <= pull_d;
            tx_start_o  <= start_d;
            drain_o     <= drain_d;
            err_o       <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: queue-based FIFO and transmitter models plus a scoreboard of expected characters and counts.
module tb_uart_tx_scheduler;

    localparam int DW     = 8;
    localparam int GW     = 8;
    localparam int CW     = 16;
    localparam int ACK_TO = 4;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic          clear_i;
    logic          enable_i;
    logic [GW-1:0] gap_i;
    logic          fifo_load_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_pull_o;
    logic          tx_busy_i;
    logic          tx_start_o;
    logic [DW-1:0] tx_data_o;
    logic [CW-1:0] sent_cnt_o;
    logic          drain_o;
    logic          err_o;

    uart_tx_scheduler #(
        .DATA_SIZE  (DW),
        .GAP_WIDTH  (GW),
        .CNT_WIDTH  (CW),
        .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .clear_i    (clear_i),
        .enable_i   (enable_i),
        .gap_i      (gap_i),
        .fifo_load_i(fifo_load_i),
        .fifo_data_i(fifo_data_i),
        .fifo_pull_o(fifo_pull_o),
        .tx_busy_i  (tx_busy_i),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .sent_cnt_o (sent_cnt_o),
        .drain_o    (drain_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_sent;
    int  cyc, pulls, starts, drains, completions;
    int  ack_lat, busy_len, xphase, ack_left, busy_left;
    int  drop_cyc, drop_gap, start_cyc;
    bit  no_ack, cur_counted, drop_pend, prev_start, scramble;

    task automatic refresh_fifo();
        fifo_load_i = (fq.size() != 0);
        fifo_data_i = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
        refresh_fifo();
    endtask

    // One clock: observe registered outputs just after the edge, then advance the models.
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        if (fifo_pull_o || tx_start_o) check("pull_with_start", int'(fifo_pull_o), int'(tx_start_o));
        if (fifo_pull_o) begin
            check("pull_nonempty", int'(fq.size() != 0), 1);
            pulls++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
        if (drain_o) drains++;
        if (xphase == 1) begin
            ack_left--;
            if (ack_left == 0) begin
                tx_busy_i = 1'b1;
                xphase    = 2;
            end
        end else if (xphase == 2) begin
            busy_left--;
            if (busy_left == 0) begin
                tx_busy_i = 1'b0;
                xphase    = 0;
                completions++;
                if (cur_counted) begin
                    exp_sent = exp_sent + 1'b1;
                    if (fq.size() != 0 && enable_i) begin
                        drop_pend = 1'b1;
                        drop_cyc  = cyc;
                        drop_gap  = int'(gap_i);
                    end
                end
            end
        end
        if (scramble && drop_pend && cyc == drop_cyc + 2) gap_i = GW'($urandom_range(1, 20));
        if (tx_start_o) begin
            check("start_not_b2b", int'(prev_start), 0);
            if (exp_q.size() != 0) check("tx_data", int'(tx_data_o), int'(exp_q.pop_front()));
            else                   check("start_unexpected", 1, 0);
            // Busy seen low on one edge, gap cycles in GAP, one IDLE cycle, then start.
            if (drop_pend) check("spacing", cyc - drop_cyc, drop_gap + 2);
            drop_pend   = 1'b0;
            starts++;
            start_cyc   = cyc;
            cur_counted = 1'b1;
            if (!no_ack) begin
                xphase   = 1;
                ack_left = ack_lat;
                busy_left = busy_len;
            end
        end
        prev_start = tx_start_o;
        refresh_fifo();
    endtask

    task automatic run_until_complete(input int target, input int budget);
        int n = 0;
        while (completions < target && n < budget) begin
            step();
            n++;
        end
        if (completions < target) check("timeout_completion", completions, target);
        repeat (12) step();
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!tx_busy_i && n < budget) begin
            step();
            n++;
        end
        if (!tx_busy_i) check("timeout_busy", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, int'(tx_start_o), 0);
        check({tag, "_pull"},  int'(fifo_pull_o), 0);
        check({tag, "_data"},  int'(tx_data_o), 0);
        check({tag, "_cnt"},   int'(sent_cnt_o), 0);
        check({tag, "_drain"}, int'(drain_o), 0);
        check({tag, "_err"},   int'(err_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, d0, s0, n, c0;
        arst_i = 1'b0; clear_i = 1'b0; enable_i = 1'b0; gap_i = '0;
        fifo_load_i = 1'b0; fifo_data_i = '0; tx_busy_i = 1'b0;
        exp_sent = '0; cyc = 0; pulls = 0; starts = 0; drains = 0; completions = 0;
        ack_lat = 1; busy_len = 10; xphase = 0; ack_left = 0; busy_left = 0;
        drop_cyc = 0; drop_gap = 0; start_cyc = 0;
        no_ack = 1'b0; cur_counted = 1'b0; drop_pend = 1'b0; prev_start = 1'b0; scramble = 1'b0;

        #1 arst_i = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk_i) arst_i = 1'b0;

        // Two characters, no gap, 1-cycle ack, 10 busy cycles.
        enable_i = 1'b1;
        p0 = pulls; d0 = drains; s0 = starts;
        push(8'h41); push(8'h42);
        run_until_complete(completions + 2, 200);
        check("basic_pulls",  pulls - p0, 2);
        check("basic_starts", starts - s0, 2);
        check("basic_cnt",    int'(sent_cnt_o), 2);
        check("basic_drains", drains - d0, 1);

        // Gap of 5, gap_i disturbed while in GAP.
        gap_i = 8'd5; scramble = 1'b1;
        push(DW'($urandom)); push(DW'($urandom));
        run_until_complete(completions + 2, 200);
        scramble = 1'b0;
        check("gap_cnt", int'(sent_cnt_o), int'(exp_sent));

        // Randomized bursts.
        for (int r = 0; r < 8; r++) begin
            gap_i    = GW'($urandom_range(0, 6));
            ack_lat  = int'($urandom_range(1, ACK_TO - 1));
            busy_len = int'($urandom_range(1, 12));
            n        = int'($urandom_range(1, 4));
            p0 = pulls; d0 = drains;
            for (int k = 0; k < n; k++) push(DW'($urandom));
            run_until_complete(completions + n, 400);
            check("rand_pulls",  pulls - p0, n);
            check("rand_drains", drains - d0, 1);
            check("rand_cnt",    int'(sent_cnt_o), int'(exp_sent));
        end

        // Transmitter never acknowledges.
        gap_i = '0; ack_lat = 1; busy_len = 10; no_ack = 1'b1;
        s0 = starts;
        push(DW'($urandom));
        n = 0;
        while (starts == s0 && n < 20) begin step(); n++; end
        check("timeout_started", starts - s0, 1);
        n = 0;
        while (!err_o && n < 10) begin step(); n++; end
        check("timeout_err", int'(err_o), 1);
        check("timeout_latency", int'((cyc - start_cyc) <= ACK_TO + 1), 1);
        check("timeout_cnt", int'(sent_cnt_o), int'(exp_sent));
        no_ack = 1'b0;
        push(DW'($urandom));
        run_until_complete(completions + 1, 100);
        check("after_timeout_cnt", int'(sent_cnt_o), int'(exp_sent));
        check("err_sticky", int'(err_o), 1);

        // Enable dropped while the character is in flight.
        push(DW'($urandom)); push(DW'($urandom));
        wait_busy(20);
        enable_i = 1'b0;
        s0 = starts; c0 = int'(exp_sent);
        run_until_complete(completions + 1, 100);
        repeat (10) step();
        check("en_off_no_start", starts - s0, 0);
        check("en_off_cnt", int'(sent_cnt_o), c0 + 1);
        enable_i = 1'b1;
        run_until_complete(completions + 1, 100);
        check("en_on_cnt", int'(sent_cnt_o), c0 + 2);

        // Soft clear in IDLE, then in WAIT_DONE with three counted.
        @(negedge clk_i) clear_i = 1'b1;
        step();
        clear_i = 1'b0; exp_sent = '0;
        check("clear_err", int'(err_o), 0);
        check("clear_cnt", int'(sent_cnt_o), 0);
        for (int k = 0; k < 3; k++) push(DW'($urandom));
        run_until_complete(completions + 3, 200);
        check("pre_clear_cnt", int'(sent_cnt_o), 3);
        push(DW'($urandom));
        wait_busy(20);
        step(); step();
        clear_i = 1'b1; cur_counted = 1'b0;
        step();
        clear_i = 1'b0; exp_sent = '0;
        check("clr_wd_cnt", int'(sent_cnt_o), 0);
        check("clr_wd_err", int'(err_o), 0);
        check("clr_wd_start", int'(tx_start_o), 0);
        run_until_complete(completions + 1, 100);
        check("clr_abandon_cnt", int'(sent_cnt_o), 0);
        push(DW'($urandom));
        run_until_complete(completions + 1, 100);
        check("clr_resume_cnt", int'(sent_cnt_o), 1);

        // Async reset in the middle of a long gap.
        gap_i = 8'd10;
        push(DW'($urandom));
        c0 = completions;
        n = 0;
        while (completions == c0 && n < 100) begin step(); n++; end
        check("arst_pre_done", completions - c0, 1);
        step(); step(); step();
        check("arst_pre_cnt", int'(sent_cnt_o), int'(exp_sent));
        @(negedge clk_i);
        arst_i = 1'b1;
        #1 check_all_zero("arst_gap");
        @(negedge clk_i);
        arst_i = 1'b0;
        exp_sent = '0; xphase = 0; tx_busy_i = 1'b0; drop_pend = 1'b0; prev_start = 1'b0;

        // Counter wrap.
        gap_i = '0;
        @(negedge clk_i);
        force dut.sent_cnt_o = 16'hFFFF;
        #1 release dut.sent_cnt_o;
        exp_sent = 16'hFFFF;
        step();
        check("wrap_preload", int'(sent_cnt_o), 32'hFFFF);
        push(DW'($urandom));
        run_until_complete(completions + 1, 100);
        check("wrap_cnt", int'(sent_cnt_o), int'(exp_sent));
        check("wrap_zero", int'(sent_cnt_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
